mem_arbiter: RTL

Arbitrates the single RAM port between the instruction cache and the data cache of the pipelined MIPS core. It sits between the caches and the RAM model. It serialises their requests with data-side priority and a starvation guard, tracks each transaction to completion, and returns per-requester hit pulses and load data. The datapath's pcWEN and pipeline-latch enables are driven from these `ihit`/`dhit` pulses.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the single RAM port between the icache and dcache.
// The dcache has priority. A starvation guard forces an icache grant after
// STARVE_LIMIT consecutive dcache grants that were taken while the icache
// was waiting.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   iREN, iaddr           icache read request (level) and word address
//   ihit, iload           icache completion pulse and read data
//   dREN, dWEN            dcache read/write requests (level)
//   daddr, dstore         dcache word address and write data
//   dhit, dload           dcache completion pulse and read data
//   ramREN, ramWEN        RAM read/write strobes
//   ramaddr, ramstore     RAM address and write data
//   ramload, ramstate     RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   owner                 current grant: 0 none, 1 icache, 2 dcache
//   err_count             saturating count of RAM ERROR responses
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ERR_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             iREN,
    input  logic [31:0]      iaddr,
    output logic             ihit,
    output logic [31:0]      iload,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic [31:0]      daddr,
    input  logic [31:0]      dstore,
    output logic             dhit,
    output logic [31:0]      dload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate,
    output logic [1:0]       owner,
    output logic [ERR_W-1:0] err_count
);

    // Encodings chosen so that owner is simply the state value.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StIsvc = 2'd1,
        StDsvc = 2'd2
    } state_e;

    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e           r_state;
    state_e           w_state_d;
    logic [3:0]       r_starve_cnt;
    logic [3:0]       w_starve_d;
    logic [ERR_W-1:0] r_err_count;
    logic             w_err_inc;
    logic             w_dreq;

    assign w_dreq = dREN | dWEN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= StIdle;
            r_starve_cnt <= 4'd0;
            r_err_count  <= '0;
        end else begin
            r_state      <= w_state_d;
            r_starve_cnt <= w_starve_d;
            if (w_err_inc && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_starve_d = r_starve_cnt;
        w_err_inc  = 1'b0;
        ihit       = 1'b0;
        iload      = 32'd0;
        dhit       = 1'b0;
        dload      = 32'd0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'd0;
        ramstore   = 32'd0;

        unique case (r_state)
            StIdle: begin
                if (!iREN) begin
                    w_starve_d = 4'd0;
                end
                if (w_dreq && !(iREN && (r_starve_cnt == StarveMax))) begin
                    w_state_d = StDsvc;
                    if (iREN) begin
                        w_starve_d = r_starve_cnt + 4'd1;
                    end
                end else if (iREN) begin
                    w_state_d  = StIsvc;
                    w_starve_d = 4'd0;
                end
            end

            StIsvc: begin
                // Requester withdrew: strobes drop now, no hit, back to idle.
                if (!iREN) begin
                    w_state_d = StIdle;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == RamAccess) begin
                        ihit      = 1'b1;
                        iload     = ramload;
                        w_state_d = StIdle;
                    end else if (ramstate == RamError) begin
                        w_err_inc = 1'b1;
                    end
                end
            end

            StDsvc: begin
                if (!w_dreq) begin
                    w_state_d = StIdle;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    // Write takes precedence when both request lines are up.
                    ramWEN   = dWEN;
                    ramREN   = !dWEN;
                    if (ramstate == RamAccess) begin
                        dhit      = 1'b1;
                        dload     = dWEN ? 32'd0 : ramload;
                        w_state_d = StIdle;
                    end else if (ramstate == RamError) begin
                        w_err_inc = 1'b1;
                    end
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign owner     = r_state;
    assign err_count = r_err_count;

endmodule
